apb_i2c_csr: RTL

//  Parametrised APB3 slave front-end for the I2C core; next generation of the APB/I2C glue.

---
 rtl/apb_i2c_csr.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/apb_i2c_csr.sv
// APB3 slave front-end for the I2C core: TX/RX FIFO data ports with wait states, CSR file,
// and a maskable W1C interrupt block.
//   state     | meaning
//   S_IDLE    | no transfer in flight; decodes a new access
//   S_TXWAIT  | TXDATA write stalled on TX_FULL, timer counts down to the error response
//   S_RXLAT   | RX pop issued, timer counts down the read latency
module apb_i2c_csr #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                CFG_W    = 14,
  parameter int                TO_W     = 14,
  parameter logic [CFG_W-1:0]  CFG_RST  = '0,
  parameter int                RD_LAT   = 1,
  parameter int                WAIT_MAX = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] TX_WDATA,
  output logic              TX_WR,
  input  logic              TX_FULL,
  input  logic              TX_EMPTY,
  output logic              RX_RD,
  input  logic [DATA_W-1:0] RX_RDATA,
  input  logic              RX_EMPTY,
  input  logic              I2C_ERROR,
  output logic [CFG_W-1:0]  I2C_CONFIG,
  output logic [TO_W-1:0]   I2C_TIMEOUT,
  output logic              IRQ
);

  localparam int CNT_MAX = (WAIT_MAX > RD_LAT) ? WAIT_MAX : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'('h00);
  localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'('h08);
  localparam logic [ADDR_W-1:0] A_TO   = ADDR_W'('h0C);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'('h10);
  localparam logic [ADDR_W-1:0] A_IEN  = ADDR_W'('h14);
  localparam logic [ADDR_W-1:0] A_IST  = ADDR_W'('h18);

  typedef enum logic [1:0] {S_IDLE, S_TXWAIT, S_RXLAT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CFG_W-1:0]  cfg_q;
  logic [TO_W-1:0]   to_q;
  logic [2:0]        int_en_q, int_stat_q, int_set, int_clr;
  logic              irq_q, tx_empty_q, rx_empty_q, err_q;
  logic              access, legal, is_tx, is_rx, csr_we;
  logic [DATA_W-1:0] csr_rdata;

  assign access      = PSELx & PENABLE;
  assign TX_WDATA    = PWDATA;
  assign I2C_CONFIG  = cfg_q;
  assign I2C_TIMEOUT = to_q;
  assign IRQ         = irq_q;

  // Exact-match decode: unaligned and unmapped addresses fall through to the error path.
  always_comb begin
    csr_rdata = '0;
    legal     = 1'b0;
    is_tx     = 1'b0;
    is_rx     = 1'b0;
    case (PADDR)
      A_TX:   begin legal = PWRITE;  is_tx = 1'b1; end
      A_RX:   begin legal = !PWRITE; is_rx = 1'b1; end
      A_CFG:  begin legal = 1'b1; csr_rdata = DATA_W'(cfg_q); end
      A_TO:   begin legal = 1'b1; csr_rdata = DATA_W'(to_q); end
      A_STAT: begin
        legal     = !PWRITE;
        csr_rdata = DATA_W'({I2C_ERROR, TX_FULL, RX_EMPTY, TX_EMPTY});
      end
      A_IEN:  begin legal = 1'b1; csr_rdata = DATA_W'(int_en_q); end
      A_IST:  begin legal = 1'b1; csr_rdata = DATA_W'(int_stat_q); end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    TX_WR   = 1'b0;
    RX_RD   = 1'b0;
    csr_we  = 1'b0;
    case (state_q)
      S_IDLE: if (access) begin
        if (!legal) begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
        end else if (is_tx) begin
          if (!TX_FULL) begin
            TX_WR  = 1'b1;
            PREADY = 1'b1;
          end else begin
            state_d = S_TXWAIT;
            cnt_d   = CNT_W'(WAIT_MAX - 1);
          end
        end else if (is_rx) begin
          if (RX_EMPTY) begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
          end else begin
            RX_RD   = 1'b1;
            state_d = S_RXLAT;
            cnt_d   = CNT_W'(RD_LAT - 1);
          end
        end else begin
          PREADY = 1'b1;
          csr_we = PWRITE;
          if (!PWRITE) PRDATA = csr_rdata;
        end
      end
      S_TXWAIT: begin
        if (!PSELx) begin
          state_d = S_IDLE;
        end else if (!TX_FULL) begin
          TX_WR   = 1'b1;
          PREADY  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RXLAT: begin
        if (!PSELx) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          PREADY  = 1'b1;
          PRDATA  = RX_RDATA;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Strobes and handshake must stay low while reset is held, even with an access pending.
    if (!PRESETn) begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
      TX_WR   = 1'b0;
      RX_RD   = 1'b0;
      csr_we  = 1'b0;
    end
  end

  assign int_set = {I2C_ERROR & ~err_q, rx_empty_q & ~RX_EMPTY, TX_EMPTY & ~tx_empty_q};
  assign int_clr = (csr_we && PADDR == A_IST) ? PWDATA[2:0] : 3'b000;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_q      <= CFG_RST;
      to_q       <= '0;
      int_en_q   <= '0;
      int_stat_q <= '0;
      irq_q      <= 1'b0;
      tx_empty_q <= 1'b1;
      rx_empty_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_empty_q <= TX_EMPTY;
      rx_empty_q <= RX_EMPTY;
      err_q      <= I2C_ERROR;
      if (csr_we && PADDR == A_CFG) cfg_q    <= PWDATA[CFG_W-1:0];
      if (csr_we && PADDR == A_TO)  to_q     <= PWDATA[TO_W-1:0];
      if (csr_we && PADDR == A_IEN) int_en_q <= PWDATA[2:0];
      // A set event in the same cycle as a W1C clear wins.
      int_stat_q <= (int_stat_q & ~int_clr) | int_set;
      irq_q      <= |(int_stat_q & int_en_q);
    end
  end

endmodule
